// File: rtl/dec_pkg.sv
// Shared state type and select-decode helpers for seq_decoder.
// Range checking is enabled by defining DEC_RANGE_CHK_EN when building seq_decoder.
package dec_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int unsigned MAX_SEL_W = 8;
    localparam int unsigned MAX_OUT   = 1 << MAX_SEL_W;

    // Width of a down-counter that must hold HOLD_CYC-1.
    function automatic int unsigned cnt_width(input int unsigned hold_cyc);
        return $clog2(hold_cyc + 1);
    endfunction

    function automatic logic sel_in_range(input logic [MAX_SEL_W-1:0] sel,
                                          input int unsigned         num_out);
        return (32'(sel) < num_out);
    endfunction

    // One-hot of sel over the widest supported output; all-zero when out of range.
    function automatic logic [MAX_OUT-1:0] onehot(input logic [MAX_SEL_W-1:0] sel,
                                                  input int unsigned         num_out);
        logic [MAX_OUT-1:0] v;
        v = '0;
        if (sel_in_range(sel, num_out)) begin
            v[sel] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/dec_hold_cnt.sv
// Loadable down-counter that stops at zero; times how long a decoded line is held.
module dec_hold_cnt #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/seq_decoder.sv
// Registered SEL_W-to-NUM_OUT one-hot decoder with valid/ready intake and timed hold.
// Optional feature: define DEC_RANGE_CHK_EN to reject out-of-range selects with an err pulse.
module seq_decoder
    import dec_pkg::*;
#(
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned NUM_OUT  = 4,
    parameter int unsigned HOLD_CYC = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   sel,
    input  logic               en,
    output logic [NUM_OUT-1:0] y,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned     CNT_W    = cnt_width(HOLD_CYC);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYC - 1);

    state_e             state_q, state_d;
    logic [NUM_OUT-1:0] y_q, y_d;
    logic               busy_q, busy_d;
    logic               accept_c;
    logic               cnt_load_c;
    logic               cnt_zero_c;
    logic [CNT_W-1:0]   cnt_c;
    logic [MAX_SEL_W-1:0] sel_ext_c;

    dec_hold_cnt #(
        .W (CNT_W)
    ) u_hold_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load_c),
        .load_val (LOAD_VAL),
        .cnt      (cnt_c),
        .zero     (cnt_zero_c)
    );

    // A new request may land in IDLE or in the final hold cycle, giving seamless back-to-back lines.
    assign in_ready  = rst_n & ((state_q == IDLE) | ((state_q == HOLD) & cnt_zero_c));
    assign accept_c  = in_valid & in_ready;
    assign sel_ext_c = MAX_SEL_W'(sel);

`ifdef DEC_RANGE_CHK_EN
    logic err_q, err_d;
    logic in_range_c;

    assign in_range_c = sel_in_range(sel_ext_c, NUM_OUT);
`endif

    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        busy_d     = busy_q;
        cnt_load_c = 1'b0;
`ifdef DEC_RANGE_CHK_EN
        err_d      = 1'b0;
`endif
        if (accept_c) begin
            // Out-of-range selects decode to zero, so they behave like en=0 requests.
            state_d    = HOLD;
            y_d        = en ? NUM_OUT'(onehot(sel_ext_c, NUM_OUT)) : '0;
            busy_d     = 1'b1;
            cnt_load_c = 1'b1;
`ifdef DEC_RANGE_CHK_EN
            if (!in_range_c) begin
                state_d    = IDLE;
                y_d        = '0;
                busy_d     = 1'b0;
                cnt_load_c = 1'b0;
                err_d      = 1'b1;
            end
`endif
        end else if ((state_q == HOLD) && cnt_zero_c) begin
            state_d = IDLE;
            y_d     = '0;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
        end
    end

`ifdef DEC_RANGE_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign y    = y_q;
    assign busy = busy_q;
    assign done = (state_q == HOLD) & cnt_zero_c;

    a_y_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(y_q));
    a_idle_cnt_zero : assert property (@(posedge clk) disable iff (!rst_n)
                                       (state_q == IDLE) |-> (cnt_c == '0));

endmodule

// File: tb/tb_seq_decoder.sv
// Scoreboard bench for seq_decoder: directed requests push expected segments, monitors check outputs.
module tb_seq_decoder;

    localparam int HOLD_A = 1;
    localparam int HOLD_B = 3;
`ifdef DEC_RANGE_CHK_EN
    localparam bit RCHK = 1'b1;
`else
    localparam bit RCHK = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] y;
        logic       err;
        logic       abort;
    } exp_t;

    logic clk;
    logic rst_n;
    logic       vld_w [2];
    logic [2:0] sel_w [2];
    logic       en_w  [2];

    logic [3:0] y_a;
    logic [4:0] y_b;
    logic rdy_a, busy_a, done_a, err_a;
    logic rdy_b, busy_b, done_b, err_b;

    logic [7:0] y_w    [2];
    logic       rdy_w  [2];
    logic       busy_w [2];
    logic       done_w [2];
    logic       err_w  [2];

    exp_t q0 [$];
    exp_t q1 [$];
    int n_tests = 0;
    int n_fail  = 0;

    seq_decoder #(.SEL_W(2), .NUM_OUT(4), .HOLD_CYC(HOLD_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(vld_w[0]), .in_ready(rdy_a),
        .sel(sel_w[0][1:0]), .en(en_w[0]), .y(y_a), .busy(busy_a),
        .done(done_a), .err(err_a)
    );

    seq_decoder #(.SEL_W(3), .NUM_OUT(5), .HOLD_CYC(HOLD_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(vld_w[1]), .in_ready(rdy_b),
        .sel(sel_w[1]), .en(en_w[1]), .y(y_b), .busy(busy_b),
        .done(done_b), .err(err_b)
    );

    always_comb begin
        y_w[0] = 8'(y_a);   y_w[1] = 8'(y_b);
        rdy_w[0] = rdy_a;   rdy_w[1] = rdy_b;
        busy_w[0] = busy_a; busy_w[1] = busy_b;
        done_w[0] = done_a; done_w[1] = done_b;
        err_w[0] = err_a;   err_w[1] = err_b;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int kk, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %0h expected %0h at %0t", kk, nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int kk, input exp_t it);
        if (kk == 0) q0.push_back(it);
        else         q1.push_back(it);
    endtask

    function automatic int qsize(input int kk);
        return (kk == 0) ? q0.size() : q1.size();
    endfunction

    task automatic pop_exp(input int kk, output exp_t it);
        if (kk == 0) it = q0.pop_front();
        else         it = q1.pop_front();
    endtask

    // Called at negedge+1; returns at negedge+1 after the accepting edge, in_valid still high.
    task automatic send(input int kk, input logic [2:0] s, input logic e,
                        input logic [7:0] ey, input logic eerr, input logic abort);
        int w;
        exp_t it;
        w = 0;
        vld_w[kk] = 1'b1;
        sel_w[kk] = s;
        en_w[kk]  = e;
        while (!rdy_w[kk] && w < 50) begin
            @(negedge clk); #1;
            w++;
        end
        n_tests++;
        if (w >= 50) begin
            n_fail++;
            $display("FAIL dut%0d handshake_timeout: in_ready stayed %0b, required 1", kk, rdy_w[kk]);
        end
        it.y = ey; it.err = eerr; it.abort = abort;
        push_exp(kk, it);
        @(negedge clk); #1;
    endtask

    task automatic drop(input int kk);
        vld_w[kk] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #1;
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_mon
        localparam int HOLD = (k == 0) ? HOLD_A : HOLD_B;
        bit   in_seg = 1'b0;
        int   cnt    = 0;
        exp_t cur;
        exp_t it;

        always @(negedge clk) begin
            if (!rst_n) begin
                if (in_seg) begin
                    chk(k, "seg_aborted_by_reset", 32'(cur.abort), 32'd1);
                    in_seg = 1'b0;
                end
                chk(k, "rst_y", 32'(y_w[k]), 32'd0);
                chk(k, "rst_busy", 32'(busy_w[k]), 32'd0);
                chk(k, "rst_in_ready", 32'(rdy_w[k]), 32'd0);
                chk(k, "rst_done", 32'(done_w[k]), 32'd0);
                chk(k, "rst_err", 32'(err_w[k]), 32'd0);
            end else begin
                chk(k, "onehot0", 32'($onehot0(y_w[k])), 32'd1);
                if (err_w[k]) begin
                    if (qsize(k) == 0) begin
                        chk(k, "err_without_request", 32'(err_w[k]), 32'd0);
                    end else begin
                        pop_exp(k, it);
                        chk(k, "err_expected", 32'(it.err), 32'd1);
                        chk(k, "err_busy", 32'(busy_w[k]), 32'd0);
                    end
                end
                if (busy_w[k] && !in_seg) begin
                    if (qsize(k) == 0) begin
                        chk(k, "busy_without_request", 32'(busy_w[k]), 32'd0);
                    end else begin
                        pop_exp(k, cur);
                        chk(k, "seg_err_expected", 32'(cur.err), 32'd0);
                        in_seg = 1'b1;
                        cnt    = 0;
                    end
                end
                if (in_seg) begin
                    cnt++;
                    chk(k, "hold_y", 32'(y_w[k]), 32'(cur.y));
                    chk(k, "hold_busy", 32'(busy_w[k]), 32'd1);
                    chk(k, "hold_done", 32'(done_w[k]), 32'(cnt == HOLD));
                    chk(k, "hold_in_ready", 32'(rdy_w[k]), 32'(cnt == HOLD));
                    if (done_w[k] || cnt >= HOLD) begin
                        if (done_w[k]) chk(k, "done_on_aborted_seg", 32'(cur.abort), 32'd0);
                        in_seg = 1'b0;
                    end
                end else if (!busy_w[k]) begin
                    chk(k, "idle_y", 32'(y_w[k]), 32'd0);
                    chk(k, "idle_done", 32'(done_w[k]), 32'd0);
                    chk(k, "idle_in_ready", 32'(rdy_w[k]), 32'd1);
                end
            end
        end
    end

    initial begin
        int w;
        for (int i = 0; i < 2; i++) begin
            vld_w[i] = 1'b0;
            sel_w[i] = '0;
            en_w[i]  = 1'b0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        idle(1);

        // Single-cycle decode of every line, with idle gaps
        send(0, 3'd0, 1'b1, 8'h01, 1'b0, 1'b0); drop(0); idle(2);
        send(0, 3'd1, 1'b1, 8'h02, 1'b0, 1'b0); drop(0); idle(2);
        send(0, 3'd2, 1'b1, 8'h04, 1'b0, 1'b0); drop(0); idle(2);
        send(0, 3'd3, 1'b1, 8'h08, 1'b0, 1'b0); drop(0); idle(2);

        // Back-to-back with HOLD_CYC=1, then en=0
        send(0, 3'd3, 1'b1, 8'h08, 1'b0, 1'b0);
        send(0, 3'd0, 1'b1, 8'h01, 1'b0, 1'b0);
        send(0, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0); drop(0); idle(2);

        // sel/en wiggling without in_valid must not assert anything
        for (int i = 0; i < 4; i++) begin
            sel_w[0] = 3'(i);
            en_w[0]  = 1'b1;
            idle(1);
        end
        idle(2);

        // Three-cycle hold, then seamless back-to-back
        send(1, 3'd2, 1'b1, 8'h04, 1'b0, 1'b0); drop(1); idle(5);
        send(1, 3'd1, 1'b1, 8'h02, 1'b0, 1'b0);
        send(1, 3'd4, 1'b1, 8'h10, 1'b0, 1'b0); drop(1); idle(5);

        // en=0 keeps timing with y=0
        send(1, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0); drop(1); idle(5);

        // Out-of-range select from IDLE, and at the final-hold-cycle slot
        send(1, 3'd6, 1'b1, 8'h00, RCHK, 1'b0); drop(1); idle(5);
        send(1, 3'd1, 1'b1, 8'h02, 1'b0, 1'b0);
        send(1, 3'd7, 1'b1, 8'h00, RCHK, 1'b0); drop(1); idle(5);

        // Reset during hold cycle 2: y clears at once, no done
        send(1, 3'd3, 1'b1, 8'h08, 1'b0, 1'b1); drop(1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk(1, "async_clear_y", 32'(y_b), 32'd0);
        chk(1, "async_clear_busy", 32'(busy_b), 32'd0);
        chk(1, "async_clear_done", 32'(done_b), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        idle(2);
        send(1, 3'd0, 1'b1, 8'h01, 1'b0, 1'b0); drop(1); idle(5);

        w = 0;
        while ((q0.size() != 0 || q1.size() != 0 || g_mon[0].in_seg || g_mon[1].in_seg) && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_tests++;
        if (w >= 200) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d/%0d expected segments still pending, required 0",
                     q0.size(), q1.size());
        end
        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
